// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl_if
// Purpose  : Valid/ready load channel carrying a new display value into
//            seg_scan_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8
) ();
    logic                    load_valid;
    logic                    load_ready;
    logic [4*NUM_DIGITS-1:0] load_data;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : Scans a common-anode multi-digit 7-segment display with
//            per-slot blanking and frame-synchronous value updates.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg_scan_ctrl_if.slave        load,
    input  logic                  lz_en,
    input  logic [NUM_DIGITS-1:0] digit_en,
    input  logic [NUM_DIGITS-1:0] dp_en,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_start
);

    localparam int c_cnt_w = $clog2(REFRESH_DIV);
    localparam int c_idx_w = $clog2(NUM_DIGITS);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_blank   = c_cnt_w'(BLANK_CYCLES);
    localparam logic [c_idx_w-1:0] c_idx_max = c_idx_w'(NUM_DIGITS - 1);

    localparam logic [0:0] c_st_blank = 1'b0;
    localparam logic [0:0] c_st_show  = 1'b1;

    logic [c_cnt_w-1:0]      r_cnt;
    logic [c_idx_w-1:0]      r_idx;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic                    r_pending;
    logic                    r_load_ready;
    logic                    r_started;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic                    r_frame_start;

    logic [c_cnt_w-1:0]      w_cnt_nxt;
    logic [c_idx_w-1:0]      w_idx_nxt;
    logic [4*NUM_DIGITS-1:0] w_disp_nxt;
    logic                    w_wrap;
    logic                    w_commit;
    logic                    w_accept;
    logic [0:0]              w_state;
    logic                    w_lit;
    logic [NUM_DIGITS-1:0]   w_an_nxt;
    logic [6:0]              w_seg_nxt;
    logic                    w_dp_nxt;
    logic [3:0]              w_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_hi_zero;

    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        case (h)
            4'h0:    hex2seg = 7'b0000001;
            4'h1:    hex2seg = 7'b1001111;
            4'h2:    hex2seg = 7'b0010010;
            4'h3:    hex2seg = 7'b0000110;
            4'h4:    hex2seg = 7'b1001100;
            4'h5:    hex2seg = 7'b0100100;
            4'h6:    hex2seg = 7'b0100000;
            4'h7:    hex2seg = 7'b0001111;
            4'h8:    hex2seg = 7'b0000000;
            4'h9:    hex2seg = 7'b0000100;
            4'hA:    hex2seg = 7'b0001000;
            4'hB:    hex2seg = 7'b1100000;
            4'hC:    hex2seg = 7'b0110001;
            4'hD:    hex2seg = 7'b1000010;
            4'hE:    hex2seg = 7'b0110000;
            default: hex2seg = 7'b0111000;
        endcase
    endfunction

    assign w_wrap   = (r_cnt == c_cnt_max);
    assign w_commit = w_wrap && (r_idx == c_idx_max) && r_pending;
    assign w_accept = load.load_valid && r_load_ready;
    assign w_disp_nxt = w_commit ? r_shadow : r_disp;

    // The first cycle after reset release is held at cnt=0/idx=0 so that
    // frame_start pulses there; the scan free-runs from then on.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_idx_nxt = r_idx;
        if (r_started) begin
            if (w_wrap) begin
                w_cnt_nxt = '0;
                w_idx_nxt = (r_idx == c_idx_max) ? '0 : r_idx + 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_nib[gi]     = w_disp_nxt[4*gi +: 4];
            assign w_hi_zero[gi] = (w_disp_nxt[4*NUM_DIGITS-1:4*gi] == '0);
        end
    endgenerate

    // Outputs are computed from next-cycle state so the registered pins line
    // up with the cnt/idx values they are shown alongside.
    always_comb begin
        w_an_nxt  = '1;
        w_seg_nxt = 7'b1111111;
        w_dp_nxt  = 1'b1;
        w_state   = (w_cnt_nxt < c_blank) ? c_st_blank : c_st_show;
        w_lit     = digit_en[w_idx_nxt] &&
                    !(lz_en && (w_idx_nxt != '0) && w_hi_zero[w_idx_nxt]);
        case (w_state)
            c_st_show: begin
                if (w_lit) begin
                    w_an_nxt[w_idx_nxt] = 1'b0;
                    w_seg_nxt           = hex2seg(w_nib[w_idx_nxt]);
                    w_dp_nxt            = ~dp_en[w_idx_nxt];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_idx         <= '0;
            r_disp        <= '0;
            r_shadow      <= '0;
            r_pending     <= 1'b0;
            r_load_ready  <= 1'b1;
            r_started     <= 1'b0;
            r_an          <= '1;
            r_seg         <= 7'b1111111;
            r_dp          <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_nxt;
            r_idx         <= w_idx_nxt;
            r_disp        <= w_disp_nxt;
            r_started     <= 1'b1;
            r_an          <= w_an_nxt;
            r_seg         <= w_seg_nxt;
            r_dp          <= w_dp_nxt;
            r_frame_start <= (w_cnt_nxt == '0) && (w_idx_nxt == '0);
            if (w_commit) begin
                r_pending    <= 1'b0;
                r_load_ready <= 1'b1;
            end else if (w_accept) begin
                r_shadow     <= load.load_data;
                r_pending    <= 1'b1;
                r_load_ready <= 1'b0;
            end
        end
    end

    assign load.load_ready = r_load_ready;
    assign an              = r_an;
    assign seg             = r_seg;
    assign dp              = r_dp;
    assign frame_start     = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Purpose  : Directed self-checking bench for seg_scan_ctrl (4 digits,
//            8-cycle slots, 2 blank cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int N = 4;
    localparam int R = 8;
    localparam int B = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         lz_en;
    logic [N-1:0] digit_en;
    logic [N-1:0] dp_en;
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         dp;
    logic         frame_start;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

    seg_scan_ctrl #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .BLANK_CYCLES(B)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (bus.slave),
        .lz_en      (lz_en),
        .digit_en   (digit_en),
        .dp_en      (dp_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_start(frame_start)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go(input int target);
        while (cyc < target) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @cyc %0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_disp(input string tag, input logic [N-1:0] an_e,
                            input logic [6:0] seg_e, input logic dp_e);
        chk({tag, ".an"}, an, an_e);
        chk({tag, ".seg"}, seg, seg_e);
        chk({tag, ".dp"}, dp, dp_e);
    endtask

    initial begin
        rst_n          = 1'b0;
        lz_en          = 1'b0;
        digit_en       = 4'b1111;
        dp_en          = 4'b0000;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;

        // reset state
        repeat (3) tick();
        chk_disp("rst", 4'b1111, 7'b1111111, 1'b1);
        chk("rst.ready", bus.load_ready, 1);
        chk("rst.fs", frame_start, 0);

        // release and first frame of zeros
        rst_n = 1'b1;
        tick();
        cyc = 0;
        chk("c0.fs", frame_start, 1);
        chk("c0.an", an, 4'b1111);
        go(1);  chk("c1.an", an, 4'b1111);
        chk("c1.fs", frame_start, 0);
        go(2);  chk_disp("c2", 4'b1110, 7'b0000001, 1'b1);
        go(7);  chk("c7.an", an, 4'b1110);
        go(8);  chk("c8.an", an, 4'b1111);
        go(10); chk_disp("c10", 4'b1101, 7'b0000001, 1'b1);
        go(31); chk("c31.fs", frame_start, 0);
        go(32); chk("c32.fs", frame_start, 1);

        // mid-frame load, then a second offer while pending
        go(40);
        bus.load_valid = 1'b1;
        bus.load_data  = 16'h1A3F;
        tick();
        chk("ld.ready_drop", bus.load_ready, 0);
        bus.load_data = 16'hFFFF;
        tick();
        bus.load_valid = 1'b0;
        chk("ld.ready_held", bus.load_ready, 0);
        go(50); chk_disp("ld.old_d2", 4'b1011, 7'b0000001, 1'b1);
        go(63); chk("ld.ready_63", bus.load_ready, 0);
        chk_disp("ld.old_d3", 4'b0111, 7'b0000001, 1'b1);
        go(64); chk("ld.ready_64", bus.load_ready, 1);
        chk("ld.fs64", frame_start, 1);
        go(66); chk_disp("new.d0", 4'b1110, 7'b0111000, 1'b1);
        go(74); chk_disp("new.d1", 4'b1101, 7'b0000110, 1'b1);
        go(82); chk_disp("new.d2", 4'b1011, 7'b0001000, 1'b1);
        go(90); chk_disp("new.d3", 4'b0111, 7'b1001111, 1'b1);

        // leading-zero suppression with 0x0050
        go(96);
        chk("lz.ready", bus.load_ready, 1);
        lz_en          = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data  = 16'h0050;
        tick();
        bus.load_valid = 1'b0;
        go(130); chk_disp("lz50.d0", 4'b1110, 7'b0000001, 1'b1);
        go(138); chk_disp("lz50.d1", 4'b1101, 7'b0100100, 1'b1);
        go(146); chk_disp("lz50.d2", 4'b1111, 7'b1111111, 1'b1);
        go(154); chk_disp("lz50.d3", 4'b1111, 7'b1111111, 1'b1);

        // leading-zero suppression with 0x0000
        go(160);
        bus.load_valid = 1'b1;
        bus.load_data  = 16'h0000;
        tick();
        bus.load_valid = 1'b0;
        go(194); chk_disp("lz00.d0", 4'b1110, 7'b0000001, 1'b1);
        go(202); chk("lz00.d1", an, 4'b1111);
        go(218); chk("lz00.d3", an, 4'b1111);

        // digit enable and decimal points
        go(224);
        lz_en    = 1'b0;
        digit_en = 4'b1011;
        dp_en    = 4'b0001;
        go(226); chk_disp("en.d0", 4'b1110, 7'b0000001, 1'b0);
        go(234); chk_disp("en.d1", 4'b1101, 7'b0000001, 1'b1);
        go(242); chk_disp("en.d2", 4'b1111, 7'b1111111, 1'b1);
        go(247); chk("en.d2_end", an, 4'b1111);
        go(250); chk_disp("en.d3", 4'b0111, 7'b0000001, 1'b1);

        // reset mid-slot with a load pending
        go(256);
        digit_en       = 4'b1111;
        dp_en          = 4'b0000;
        bus.load_valid = 1'b1;
        bus.load_data  = 16'h1234;
        tick();
        bus.load_valid = 1'b0;
        chk("pr.ready", bus.load_ready, 0);
        go(277); chk("pr.d2c5", an, 4'b1011);
        rst_n = 1'b0;
        tick();
        chk_disp("pr.rst", 4'b1111, 7'b1111111, 1'b1);
        chk("pr.rst_ready", bus.load_ready, 1);
        chk("pr.rst_fs", frame_start, 0);
        rst_n = 1'b1;
        tick();
        cyc = 0;
        chk("pr.fs0", frame_start, 1);
        go(2);  chk_disp("pr.d0", 4'b1110, 7'b0000001, 1'b1);
        go(10); chk_disp("pr.d1", 4'b1101, 7'b0000001, 1'b1);

        // load accepted on the commit edge waits a full frame
        go(31);
        bus.load_valid = 1'b1;
        bus.load_data  = 16'h0007;
        tick();
        bus.load_valid = 1'b0;
        chk("ce.ready32", bus.load_ready, 0);
        go(34); chk_disp("ce.d0_old", 4'b1110, 7'b0000001, 1'b1);
        go(63); chk("ce.ready63", bus.load_ready, 0);
        go(64); chk("ce.ready64", bus.load_ready, 1);
        go(66); chk_disp("ce.d0_new", 4'b1110, 7'b0001111, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
